// File: rtl/ehgu_edge_rst_unit.sv
// ehgu_edge_rst_unit
// Per-bit edge detector (rise / fall / any-change strobes) plus an
// asynchronous-assert / synchronous-deassert reset synchronizer. The two
// halves share the clock only; rstn_out does not feed the edge logic.
module ehgu_edge_rst_unit #(
    parameter int   WIDTH       = 1,
    parameter int   SYNC_STAGES = 2,    // legal range 2..8
    parameter logic DIN_RST_VAL = 1'b0  // history reset value, every bit
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] redge,
    output logic [WIDTH-1:0] fedge,
    output logic [WIDTH-1:0] toggle,
    input  logic             rstn_in,
    output logic             rstn_out
);

    // ------------------------------------------------------------------
    // Edge detector
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] din_d_r;
    logic [WIDTH-1:0] redge_s;
    logic [WIDTH-1:0] fedge_s;
    logic [WIDTH-1:0] toggle_s;

    // History register: previous-cycle value of din.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            din_d_r <= {WIDTH{DIN_RST_VAL}};
        end else begin
            din_d_r <= din;
        end
    end

    // Strobes are combinational so a change is reported in the same cycle;
    // they are held quiet while the edge logic is in reset.
    always_comb begin
        redge_s  = {WIDTH{1'b0}};
        fedge_s  = {WIDTH{1'b0}};
        toggle_s = {WIDTH{1'b0}};
        if (rstn) begin
            redge_s  = din & ~din_d_r;
            fedge_s  = ~din & din_d_r;
            toggle_s = din ^ din_d_r;
        end else begin
            redge_s  = {WIDTH{1'b0}};
            fedge_s  = {WIDTH{1'b0}};
            toggle_s = {WIDTH{1'b0}};
        end
    end

    assign redge  = redge_s;
    assign fedge  = fedge_s;
    assign toggle = toggle_s;

    // ------------------------------------------------------------------
    // Reset synchronizer
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_r;

    // Shift a constant 1 through the chain; any low on rstn_in wipes every
    // stage at once, so a short high pulse can never reach the last stage.
    always_ff @(posedge clk or negedge rstn_in) begin
        if (!rstn_in) begin
            sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], 1'b1};
        end
    end

    // Release edge is always a flop output, hence clock-aligned.
    assign rstn_out = sync_r[SYNC_STAGES-1];

endmodule

// File: tb/tb_ehgu_edge_rst_unit.sv
// Directed self-checking bench for ehgu_edge_rst_unit.
// dut_a: WIDTH=4, SYNC_STAGES=2, DIN_RST_VAL=0
// dut_b: WIDTH=1, SYNC_STAGES=3, DIN_RST_VAL=1
`timescale 1ns/100ps
module tb_ehgu_edge_rst_unit;

    logic       clk;
    logic       rstn_a;
    logic [3:0] din_a;
    logic [3:0] redge_a;
    logic [3:0] fedge_a;
    logic [3:0] toggle_a;
    logic       rstn_in_a;
    logic       rstn_out_a;

    logic       rstn_b;
    logic [0:0] din_b;
    logic [0:0] redge_b;
    logic [0:0] fedge_b;
    logic [0:0] toggle_b;
    logic       rstn_in_b;
    logic       rstn_out_b;

    int compared;
    int mismatched;

    ehgu_edge_rst_unit #(.WIDTH(4), .SYNC_STAGES(2), .DIN_RST_VAL(1'b0)) dut_a (
        .clk(clk), .rstn(rstn_a), .din(din_a), .redge(redge_a), .fedge(fedge_a),
        .toggle(toggle_a), .rstn_in(rstn_in_a), .rstn_out(rstn_out_a)
    );

    ehgu_edge_rst_unit #(.WIDTH(1), .SYNC_STAGES(3), .DIN_RST_VAL(1'b1)) dut_b (
        .clk(clk), .rstn(rstn_b), .din(din_b), .redge(redge_b), .fedge(fedge_b),
        .toggle(toggle_b), .rstn_in(rstn_in_b), .rstn_out(rstn_out_b)
    );

    initial clk = 1'b0;
    always #1 clk = ~clk;   // posedges at 1, 3, 5 ns ...

    task automatic test_reset;
        #0.05;
        compared++;
        if ({redge_a, fedge_a, toggle_a} !== 12'h000) begin
            mismatched++;
            $display("FAIL reset_edges_a: got %h want %h", {redge_a, fedge_a, toggle_a}, 12'h000);
        end
        compared++;
        if (rstn_out_a !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_rstn_out_a: got %b want %b", rstn_out_a, 1'b0);
        end
        compared++;
        if (rstn_out_b !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_rstn_out_b: got %b want %b", rstn_out_b, 1'b0);
        end
    endtask

    // Absolute schedule: starts at 0.05 ns.
    task automatic test_glitch_filter;
        #0.05 rstn_in_a = 1'b0;             // 0.1
        #0.3  rstn_in_a = 1'b1;             // 0.4
        #1.2;                               // 1.6 (after posedge 1)
        compared++;
        if (rstn_out_a !== 1'b0) begin
            mismatched++;
            $display("FAIL glitch_at_1p6: got %b want %b", rstn_out_a, 1'b0);
        end
        rstn_in_a = 1'b0;
        #1.6 rstn_in_a = 1'b1;              // 3.2
        #1.2;                               // 4.4 (after posedge 5... not yet)
        rstn_in_a = 1'b0;                   // 4.4
        for (int i = 0; i < 7; i++) begin   // 5.4 .. 11.4
            #1;
            compared++;
            if (rstn_out_a !== 1'b0) begin
                mismatched++;
                $display("FAIL glitch_hold_low_%0d: got %b want %b", i, rstn_out_a, 1'b0);
            end
        end
        rstn_in_a = 1'b1;                   // 11.4
        #1;                                 // 12.4
        compared++;
        if (rstn_out_a !== 1'b0) begin
            mismatched++;
            $display("FAIL glitch_12p4: got %b want %b", rstn_out_a, 1'b0);
        end
        #1.2;                               // 13.6
        compared++;
        if (rstn_out_a !== 1'b0) begin
            mismatched++;
            $display("FAIL glitch_13p6: got %b want %b", rstn_out_a, 1'b0);
        end
        #1.2;                               // 14.8
        compared++;
        if (rstn_out_a !== 1'b0) begin
            mismatched++;
            $display("FAIL glitch_14p8: got %b want %b", rstn_out_a, 1'b0);
        end
        #0.4;                               // 15.2
        compared++;
        if (rstn_out_a !== 1'b1) begin
            mismatched++;
            $display("FAIL glitch_release_15: got %b want %b", rstn_out_a, 1'b1);
        end
    endtask

    task automatic test_async_assert;
        @(posedge clk) #0.5 rstn_in_a = 1'b0;
        #0.1;
        compared++;
        if (rstn_out_a !== 1'b0) begin
            mismatched++;
            $display("FAIL async_assert: got %b want %b", rstn_out_a, 1'b0);
        end
        #0.1 rstn_in_a = 1'b1;
        @(posedge clk) #0.5;
        compared++;
        if (rstn_out_a !== 1'b0) begin
            mismatched++;
            $display("FAIL async_rerelease_1: got %b want %b", rstn_out_a, 1'b0);
        end
        @(posedge clk) #0.5;
        compared++;
        if (rstn_out_a !== 1'b1) begin
            mismatched++;
            $display("FAIL async_rerelease_2: got %b want %b", rstn_out_a, 1'b1);
        end
    endtask

    task automatic test_edge_single;
        @(posedge clk) #0.1 rstn_a = 1'b1;
        #0.1;
        compared++;
        if ({redge_a, fedge_a, toggle_a} !== 12'h000) begin
            mismatched++;
            $display("FAIL edge_idle: got %h want %h", {redge_a, fedge_a, toggle_a}, 12'h000);
        end
        @(posedge clk) #0.1 din_a = 4'b0001;
        #0.1;
        compared++;
        if ({redge_a, fedge_a, toggle_a} !== {4'b0001, 4'b0000, 4'b0001}) begin
            mismatched++;
            $display("FAIL edge_rise: got %h want %h", {redge_a, fedge_a, toggle_a}, {4'b0001, 4'b0000, 4'b0001});
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk) #0.05;
            compared++;
            if ({redge_a, fedge_a, toggle_a} !== 12'h000) begin
                mismatched++;
                $display("FAIL edge_hold_%0d: got %h want %h", i, {redge_a, fedge_a, toggle_a}, 12'h000);
            end
        end
        #0.05 din_a = 4'b0000;
        #0.1;
        compared++;
        if ({redge_a, fedge_a, toggle_a} !== {4'b0000, 4'b0001, 4'b0001}) begin
            mismatched++;
            $display("FAIL edge_fall: got %h want %h", {redge_a, fedge_a, toggle_a}, {4'b0000, 4'b0001, 4'b0001});
        end
        @(posedge clk) #0.5;
        compared++;
        if ({redge_a, fedge_a, toggle_a} !== 12'h000) begin
            mismatched++;
            $display("FAIL edge_after_fall: got %h want %h", {redge_a, fedge_a, toggle_a}, 12'h000);
        end
    endtask

    task automatic test_reset_during_edge;
        @(posedge clk) #0.1 din_a = 4'b0001;
        #0.1;
        compared++;
        if (redge_a !== 4'b0001) begin
            mismatched++;
            $display("FAIL rde_pre: got %b want %b", redge_a, 4'b0001);
        end
        #0.1 rstn_a = 1'b0;
        #0.1;
        compared++;
        if ({redge_a, fedge_a, toggle_a} !== 12'h000) begin
            mismatched++;
            $display("FAIL rde_forced_zero: got %h want %h", {redge_a, fedge_a, toggle_a}, 12'h000);
        end
        @(posedge clk) #0.1 rstn_a = 1'b1;
        #0.1;
        compared++;
        if ({redge_a, fedge_a, toggle_a} !== {4'b0001, 4'b0000, 4'b0001}) begin
            mismatched++;
            $display("FAIL rde_release_pulse: got %h want %h", {redge_a, fedge_a, toggle_a}, {4'b0001, 4'b0000, 4'b0001});
        end
        @(posedge clk) #0.1;
        compared++;
        if ({redge_a, fedge_a, toggle_a} !== 12'h000) begin
            mismatched++;
            $display("FAIL rde_pulse_end: got %h want %h", {redge_a, fedge_a, toggle_a}, 12'h000);
        end
        din_a = 4'b0000;
        @(posedge clk) #0.1;
    endtask

    task automatic test_multi_bit;
        compared++;
        if ({redge_a, fedge_a, toggle_a} !== 12'h000) begin
            mismatched++;
            $display("FAIL mb_idle: got %h want %h", {redge_a, fedge_a, toggle_a}, 12'h000);
        end
        din_a = 4'b1010;
        #0.1;
        compared++;
        if ({redge_a, fedge_a, toggle_a} !== {4'b1010, 4'b0000, 4'b1010}) begin
            mismatched++;
            $display("FAIL mb_step1: got %h want %h", {redge_a, fedge_a, toggle_a}, {4'b1010, 4'b0000, 4'b1010});
        end
        @(posedge clk) #0.1;
        compared++;
        if ({redge_a, fedge_a, toggle_a} !== 12'h000) begin
            mismatched++;
            $display("FAIL mb_step1_end: got %h want %h", {redge_a, fedge_a, toggle_a}, 12'h000);
        end
        din_a = 4'b0110;
        #0.1;
        compared++;
        if ({redge_a, fedge_a, toggle_a} !== {4'b0100, 4'b1000, 4'b1100}) begin
            mismatched++;
            $display("FAIL mb_step2: got %h want %h", {redge_a, fedge_a, toggle_a}, {4'b0100, 4'b1000, 4'b1100});
        end
        @(posedge clk) #0.1;
        compared++;
        if ({redge_a, fedge_a, toggle_a} !== 12'h000) begin
            mismatched++;
            $display("FAIL mb_step2_end: got %h want %h", {redge_a, fedge_a, toggle_a}, 12'h000);
        end
    endtask

    // dut_b history resets to 1, so releasing with din=0 gives a fall pulse.
    task automatic test_din_rst_val;
        @(posedge clk) #0.1 rstn_b = 1'b1;
        #0.1;
        compared++;
        if ({redge_b, fedge_b, toggle_b} !== 3'b011) begin
            mismatched++;
            $display("FAIL rstval_release: got %b want %b", {redge_b, fedge_b, toggle_b}, 3'b011);
        end
        @(posedge clk) #0.1;
        compared++;
        if ({redge_b, fedge_b, toggle_b} !== 3'b000) begin
            mismatched++;
            $display("FAIL rstval_end: got %b want %b", {redge_b, fedge_b, toggle_b}, 3'b000);
        end
    endtask

    task automatic test_sync3;
        @(posedge clk) #0.3 rstn_in_b = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk) #0.1;
            compared++;
            if (rstn_out_b !== ((i == 3) ? 1'b1 : 1'b0)) begin
                mismatched++;
                $display("FAIL sync3_edge_%0d: got %b want %b", i, rstn_out_b, ((i == 3) ? 1'b1 : 1'b0));
            end
        end
        @(posedge clk) #0.3 rstn_in_b = 1'b0;
        #0.1;
        compared++;
        if (rstn_out_b !== 1'b0) begin
            mismatched++;
            $display("FAIL sync3_async: got %b want %b", rstn_out_b, 1'b0);
        end
        #0.3 rstn_in_b = 1'b1;
        @(posedge clk);
        @(posedge clk) #0.1;
        compared++;
        if (rstn_out_b !== 1'b0) begin
            mismatched++;
            $display("FAIL sync3_short_pulse: got %b want %b", rstn_out_b, 1'b0);
        end
        rstn_in_b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk) #0.1;
            compared++;
            if (rstn_out_b !== 1'b0) begin
                mismatched++;
                $display("FAIL sync3_stay_low_%0d: got %b want %b", i, rstn_out_b, 1'b0);
            end
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rstn_a     = 1'b0;
        din_a      = 4'b0000;
        rstn_in_a  = 1'b0;
        rstn_b     = 1'b0;
        din_b      = 1'b0;
        rstn_in_b  = 1'b0;

        test_reset();
        test_glitch_filter();
        test_async_assert();
        test_edge_single();
        test_reset_during_edge();
        test_multi_bit();
        test_din_rst_val();
        test_sync3();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
